// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter with one shared single-port memory.
// Each transfer runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack pulse).
// Optional macro MEM_ARBITER_RR_EN selects round-robin arbitration on ties;
// when it is undefined, port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          gnt_id
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  xfer_t         xfer_q, xfer_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          gnt_q, gnt_d;
  logic          win_c;

`ifdef MEM_ARBITER_RR_EN
  logic          last_q, last_d;

  // Round-robin: a lone request wins; on a tie the port not granted last wins.
  always_comb begin
    win_c = req1 & (~req0 | ~last_q);
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    win_c = req1 & ~req0;
  end
`endif

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xfer_q   <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
`ifdef MEM_ARBITER_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  // Next-state logic; outputs are computed for the cycle being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xfer_d   = xfer_q;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata_d  = rdata_q;
    gnt_d    = gnt_q;
`ifdef MEM_ARBITER_RR_EN
    last_d   = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d = win_c;
          if (win_c) begin
            xfer_d.we    = we1;
            xfer_d.addr  = addr1;
            xfer_d.wdata = wdata1;
          end else begin
            xfer_d.we    = we0;
            xfer_d.addr  = addr0;
            xfer_d.wdata = wdata0;
          end
          cnt_d    = CW'(WAIT_STATES);
          mem_en_d = 1'b1;
          mem_we_d = win_c ? we1 : we0;
          state_d  = ACCESS;
`ifdef MEM_ARBITER_RR_EN
          last_d   = win_c;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!xfer_q.we) begin
            rdata_d = mem_rdata;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d    = cnt_q - CW'(1);
          mem_en_d = 1'b1;
          mem_we_d = xfer_q.we;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = xfer_q.addr;
  assign mem_wdata = xfer_q.wdata;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 (WAIT_STATES=1) runs table vectors and
// scoreboarded sequences; instance 1 (WAIT_STATES=0) checks back-to-back
// timing; instance 2 (WAIT_STATES=3) checks reset abort and long latency.
module tb_mem_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned NI = 3;

  logic          clk;
  logic          rst_n     [NI];
  logic          req0      [NI];
  logic          we0       [NI];
  logic [AW-1:0] addr0     [NI];
  logic [DW-1:0] wdata0    [NI];
  logic          req1      [NI];
  logic          we1       [NI];
  logic [AW-1:0] addr1     [NI];
  logic [DW-1:0] wdata1    [NI];
  logic [DW-1:0] mem_rdata [NI];
  logic          mem_en    [NI];
  logic          mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wdata [NI];
  logic          ack0      [NI];
  logic          ack1      [NI];
  logic [DW-1:0] rdata     [NI];
  logic          busy      [NI];
  logic          gnt_id    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    mem_arbiter #(.DW(DW), .AW(AW), .WAIT_STATES(WS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req0      (req0[g]),
      .we0       (we0[g]),
      .addr0     (addr0[g]),
      .wdata0    (wdata0[g]),
      .req1      (req1[g]),
      .we1       (we1[g]),
      .addr1     (addr1[g]),
      .wdata1    (wdata1[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .ack0      (ack0[g]),
      .ack1      (ack1[g]),
      .rdata     (rdata[g]),
      .busy      (busy[g]),
      .gnt_id    (gnt_id[g])
    );
  end

  // Memory content model: a fixed function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return (a + (a << 1)) ^ 16'h5A5A;
  endfunction

  always_comb begin
    mem_rdata[0] = mem_fn(mem_addr[0]);
    mem_rdata[1] = mem_addr[1] ^ 16'h1234;
    mem_rdata[2] = mem_addr[2] ^ 16'h1234;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          first_rr;
    logic          first_fp;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] rd_m;
  int            nchk;
  int            nbad;

  task automatic chk1(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected transaction for instance 0; rdata follows the read-only capture rule.
  task automatic push(input logic port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? rd_m : mem_fn(addr);
    rd_m    = e.rdata;
    sb.push_back(e);
  endtask

  // Per-cycle scoreboard check of instance 0, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    chk1("dual_ack", ack0[0] & ack1[0], 1'b0);
    if (mem_en[0]) begin
      chk1("access_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk16("mem_addr", mem_addr[0], e.addr);
        chk1("mem_we", mem_we[0], e.we);
        if (e.we) chk16("mem_wdata", mem_wdata[0], e.wdata);
      end
    end else begin
      chk1("mem_we_idle", mem_we[0], 1'b0);
    end
    if (ack0[0] || ack1[0]) begin
      chk1("ack_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("ack_port", ack1[0], e.port);
        chk1("gnt_id", gnt_id[0], e.port);
        chk16("rdata", rdata[0], e.rdata);
        chk1("busy_done", busy[0], 1'b1);
      end
    end
  endtask

  // One clock: monitor at the falling edge, return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Wait for n acks on instance 0 within a bounded number of cycles.
  task automatic wait_acks(input int n, input bit drop_each);
    int seen;
    seen = 0;
    for (int c = 0; c < 60 && seen < n; c++) begin
      step();
      if (ack0[0] || ack1[0]) begin
        seen++;
        if (drop_each) begin
          if (ack0[0]) req0[0] = 1'b0;
          if (ack1[0]) req1[0] = 1'b0;
        end
      end
    end
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    chk16("ack_count", 16'(seen), 16'(n));
  endtask

  task automatic drain();
    step();
    step();
    chk16("sb_drain", 16'(sb.size()), 16'd0);
    chk1("busy_idle", busy[0], 1'b0);
  endtask

  vec_t vt[8];

  initial begin
    logic first;
    int   seen;
    nchk = 0;
    nbad = 0;
    rd_m = '0;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      req0[k] = 1'b0; we0[k] = 1'b0; addr0[k] = '0; wdata0[k] = '0;
      req1[k] = 1'b0; we1[k] = 1'b0; addr1[k] = '0; wdata1[k] = '0;
    end

    //                 r0    w0    a0        d0        r1    w1    a1        d1      rr    fp
    vt[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b1, 16'h0005, 16'hAAAA, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 1'b1, 1'b1, 16'h0009, 16'h5555, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

    // Reset values on every instance.
    #12;
    for (int k = 0; k < NI; k++) begin
      chk1("rst_mem_en", mem_en[k], 1'b0);
      chk1("rst_mem_we", mem_we[k], 1'b0);
      chk1("rst_ack0", ack0[k], 1'b0);
      chk1("rst_ack1", ack1[k], 1'b0);
      chk1("rst_busy", busy[k], 1'b0);
      chk1("rst_gnt", gnt_id[k], 1'b0);
      chk16("rst_addr", mem_addr[k], 16'h0000);
      chk16("rst_wdata", mem_wdata[k], 16'h0000);
      chk16("rst_rdata", rdata[k], 16'h0000);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(posedge clk);
    #1;

    // Contention: both ports held through four transfers.
    req0[0] = 1'b1; addr0[0] = 16'h0011;
    req1[0] = 1'b1; addr1[0] = 16'h0022;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
      first = 1'(t % 2);
`else
      first = 1'b0;
`endif
      if (first) push(1'b1, 1'b0, 16'h0022, 16'h0000);
      else       push(1'b0, 1'b0, 16'h0011, 16'h0000);
    end
    wait_acks(4, 1'b0);
    drain();

    // Table vectors on instance 0.
    for (int i = 0; i < 8; i++) begin
      req0[0] = vt[i].r0; we0[0] = vt[i].w0; addr0[0] = vt[i].a0; wdata0[0] = vt[i].d0;
      req1[0] = vt[i].r1; we1[0] = vt[i].w1; addr1[0] = vt[i].a1; wdata1[0] = vt[i].d1;
      if (vt[i].r0 && vt[i].r1) begin
`ifdef MEM_ARBITER_RR_EN
        first = vt[i].first_rr;
`else
        first = vt[i].first_fp;
`endif
        if (first) begin
          push(1'b1, vt[i].w1, vt[i].a1, vt[i].d1);
          push(1'b0, vt[i].w0, vt[i].a0, vt[i].d0);
        end else begin
          push(1'b0, vt[i].w0, vt[i].a0, vt[i].d0);
          push(1'b1, vt[i].w1, vt[i].a1, vt[i].d1);
        end
        wait_acks(2, 1'b1);
      end else begin
        if (vt[i].r0) push(1'b0, vt[i].w0, vt[i].a0, vt[i].d0);
        else          push(1'b1, vt[i].w1, vt[i].a1, vt[i].d1);
        wait_acks(1, 1'b1);
      end
      drain();
    end

    // Read latency: two ACCESS cycles, ack in the third cycle after sampling.
    push(1'b0, 1'b0, 16'h0040, 16'h0000);
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 16'h0040;
    step();
    chk1("lat_c1_en", mem_en[0], 1'b1);
    chk1("lat_c1_busy", busy[0], 1'b1);
    chk1("lat_c1_ack", ack0[0], 1'b0);
    step();
    chk1("lat_c2_en", mem_en[0], 1'b1);
    chk1("lat_c2_ack", ack0[0], 1'b0);
    step();
    chk1("lat_c3_ack0", ack0[0], 1'b1);
    chk1("lat_c3_ack1", ack1[0], 1'b0);
    chk1("lat_c3_en", mem_en[0], 1'b0);
    chk16("lat_rdata", rdata[0], 16'hBEEF);
    req0[0] = 1'b0;
    drain();

    // Operand change during ACCESS must not reach the memory port.
    push(1'b0, 1'b0, 16'h0040, 16'h0000);
    req0[0] = 1'b1; addr0[0] = 16'h0040;
    step();
    addr0[0] = 16'h0041;
    wait_acks(1, 1'b1);
    drain();

    // WAIT_STATES=0 back-to-back reads with req0 held.
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 16'h0010;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk1("ws0_en", mem_en[1], (c % 3) == 1);
      chk1("ws0_ack", ack0[1], (c % 3) == 2);
      if ((c % 3) == 2) chk16("ws0_rdata", rdata[1], 16'h1224);
      if (c == 11) req0[1] = 1'b0;
    end
    step();
    chk1("ws0_idle", busy[1], 1'b0);

    // WAIT_STATES=3: reset in the second ACCESS cycle aborts without ack.
    req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 16'h0033;
    step();
    chk1("rst_acc1_en", mem_en[2], 1'b1);
    step();
    chk1("rst_acc2_en", mem_en[2], 1'b1);
    rst_n[2] = 1'b0;
    #1;
    chk1("abort_en", mem_en[2], 1'b0);
    chk1("abort_busy", busy[2], 1'b0);
    chk1("abort_ack0", ack0[2], 1'b0);
    chk16("abort_addr", mem_addr[2], 16'h0000);
    req0[2] = 1'b0;
    #2;
    rst_n[2] = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack0[2] || ack1[2]) seen++;
      chk1("abort_idle_busy", busy[2], 1'b0);
    end
    chk16("abort_no_ack", 16'(seen), 16'd0);

    // Post-reset write on port 1 served with four ACCESS cycles.
    req1[2] = 1'b1; we1[2] = 1'b1; addr1[2] = 16'h0ABC; wdata1[2] = 16'h4321;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk1("ws3_en", mem_en[2], c <= 4);
      chk1("ws3_ack1", ack1[2], c == 5);
      chk1("ws3_ack0", ack0[2], 1'b0);
      if (c <= 4) begin
        chk16("ws3_addr", mem_addr[2], 16'h0ABC);
        chk16("ws3_wdata", mem_wdata[2], 16'h4321);
        chk1("ws3_we", mem_we[2], 1'b1);
      end
      if (c == 5) begin
        chk1("ws3_gnt", gnt_id[2], 1'b1);
        chk16("ws3_rdata", rdata[2], 16'h0000);
        req1[2] = 1'b0;
      end
    end
    step();
    step();
    chk1("ws3_idle", busy[2], 1'b0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: DW, 16, data width in bits.
REQ-002 SHALL have parameter: AW, 16, address width in bits.
REQ-003 SHALL have parameter: WAIT_STATES, 1, extra memory cycles per access (0..15).
REQ-004 SHALL have ports (clock and reset first):
 clk  in  1  clock, all state changes on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 req0  in  1  port 0 (CPU load/store/fetch) request
 we0  in  1  port 0 write enable (1=write, 0=read)
 addr0  in  AW  port 0 address
 wdata0  in  DW  port 0 write data
 req1  in  1  port 1 (IO/debug loader) request
 we1  in  1  port 1 write enable
 addr1  in  AW  port 1 address
 wdata1  in  DW  port 1 write data
 mem_rdata  in  DW  memory read data, valid during access cycles
 mem_en  out  1  memory enable
 mem_we  out  1  memory write enable
 mem_addr  out  AW  memory address
 mem_wdata  out  DW  memory write data
 ack0  out  1  port 0 completion pulse
 ack1  out  1  port 1 completion pulse
 rdata  out  DW  registered read data, valid while ack0/ack1 high
 busy  out  1  transaction in progress (state != IDLE)
 gnt_id  out  1  owner of current/last transaction

Function
REQ-005 SHALL implement FSM with states IDLE, ACCESS, DONE; all outputs driven from registers.
REQ-006 IDLE: if req0 or req1 sampled high, SHALL pick winner, latch owner/we/addr/wdata, load wait counter with WAIT_STATES, go ACCESS; else stay IDLE.
REQ-007 ACCESS: SHALL drive mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, held stable every ACCESS cycle.
REQ-008 ACCESS with counter==0: SHALL capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go DONE; else decrement counter, stay ACCESS.
REQ-009 DONE: SHALL assert ack of owner for exactly one cycle, mem_en=0, go IDLE unconditionally.
REQ-010 Latency: req sampled in IDLE cycle N -> ACCESS cycles N+1..N+1+WAIT_STATES -> ack in cycle N+2+WAIT_STATES; back-to-back throughput one transfer per WAIT_STATES+3 cycles.
REQ-011 Requester SHALL hold req and operands until ack; arbiter SHALL ignore req/operand changes after latching; deassert mid-access still completes and acks.
REQ-012 Requester deasserts req on the edge ending its ack cycle; req still high in following IDLE SHALL be treated as a new request.
REQ-013 Never more than one ack high per cycle; ack never high outside DONE.
REQ-014 WAIT_STATES=0 SHALL give a single ACCESS cycle.
REQ-015 gnt_id SHALL update on latch in IDLE and hold until next grant.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, mem_en=0, mem_we=0, ack0=ack1=0, busy=0, mem_addr=0, mem_wdata=0, rdata=0, gnt_id=0, counter=0, round-robin pointer to "last=1".
REQ-017 Reset mid-ACCESS SHALL abort without ack; write in flight has undefined memory effect; first post-reset cycle is IDLE.

Configuration
REQ-018 Macro MEM_ARBITER_RR_EN defined: round-robin; on simultaneous req0/req1 the port not granted last wins; single request always wins; pointer updates on each grant; first tie after reset goes to port 0.
REQ-019 Macro undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-020 Read: WAIT_STATES=1, req0=1 we0=0 addr0=0x0040, mem_rdata=0xBEEF -> mem_en high 2 cycles, ack0 3 cycles after req sampled, rdata=0xBEEF, ack1=0.
REQ-021 Write: req1=1 we1=1 addr1=0x0100 wdata1=0x1234 -> mem_we=1 mem_addr=0x0100 mem_wdata=0x1234 during ACCESS, ack1 one cycle, rdata unchanged.
REQ-022 Contention: req0 and req1 held high for 4 transfers -> RR_EN: grants 0,1,0,1; without: 0,0,0,0 (port 1 starved).
REQ-023 Stability: change addr0 0x0040->0x0041 during ACCESS -> mem_addr stays 0x0040, ack0 still issued.
REQ-024 Reset: assert rst_n low in 2nd ACCESS cycle (WAIT_STATES=3) -> mem_en=0 same cycle, no ack, busy=0; next req served normally.
REQ-025 WAIT_STATES=0: back-to-back req0 reads -> ack0 every 3 cycles, mem_en high 1 cycle per transfer.
